ctrl_pipe_bubble: RTL and testbench

Parametrised control-signal pipeline for the pipelined CPU: carries the decoded control vector (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, …) from decode through STAGES registered stages, e.g. ID/EX, EX/MEM and MEM/WB. It replaces a purely combinational enable-or-zero gate with a sequential block. It inserts multi-cycle bubbles for load-use hazards, squashes the youngest stages on a taken branch or jump, freezes on a global stall, and counts inserted bubbles for performance debug.

---
 rtl/ctrl_pipe_bubble.sv | 117 +++++++++++
 tb/tb_ctrl_pipe_bubble.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_bubble.sv
// ctrl_pipe_bubble
//   Carries the decoded control vector of the CPU from decode through STAGES
//   registered stages (e.g. ID/EX, EX/MEM, MEM/WB). It inserts multi-cycle
//   bubbles for load-use hazards, squashes the youngest stages on a taken
//   branch or jump, freezes on a global stall, and counts inserted bubbles.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   i_ctrl_en      1 = pass i_ctrl_in, 0 = stage 0 loads an all-zero vector
//   i_ctrl_in      decoded control vector of the instruction in decode
//   i_valid_in     i_ctrl_in belongs to a real instruction
//   i_hold         global stall: freeze stages, counters and requests
//   i_flush        squash the incoming instruction and the youngest stages
//   i_bubble_req   request bubble insertion (load-use hazard)
//   i_bubble_len   number of bubbles requested, 0 = no-op
//   o_ctrl_stage   stage i vector at [i*CTRL_W +: CTRL_W], stage 0 youngest
//   o_valid_stage  per-stage valid
//   o_busy         combinational upstream stall (freeze PC and IF/ID)
//   o_bubble_left  bubbles still to insert after the current cycle
//   o_bubble_total saturating count of inserted bubbles
module ctrl_pipe_bubble #(
  parameter int CTRL_W      = 10,
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int BCNT_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_ctrl_en,
  input  logic [CTRL_W-1:0]          i_ctrl_in,
  input  logic                       i_valid_in,
  input  logic                       i_hold,
  input  logic                       i_flush,
  input  logic                       i_bubble_req,
  input  logic [BCNT_W-1:0]          i_bubble_len,
  output logic [STAGES*CTRL_W-1:0]   o_ctrl_stage,
  output logic [STAGES-1:0]          o_valid_stage,
  output logic                       o_busy,
  output logic [BCNT_W-1:0]          o_bubble_left,
  output logic [15:0]                o_bubble_total
);

  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [15:0]       TOTAL_MAX = 16'hFFFF;

  logic [STAGES-1:0][CTRL_W-1:0] r_ctrl;
  logic [STAGES-1:0]             r_valid;
  logic [BCNT_W-1:0]             r_bubble_left;
  logic [15:0]                   r_bubble_total;

  logic w_draining;
  logic w_new_bubble;
  logic w_bubble;

  // A new request is only considered once the previous run has drained, so a
  // request held high across the drain re-triggers on the first idle cycle.
  assign w_draining   = (r_bubble_left != '0);
  assign w_new_bubble = i_bubble_req && (i_bubble_len != '0) && !w_draining;
  assign w_bubble     = w_draining || w_new_bubble;

  // Flush cancels a same-cycle request, so upstream is not stalled for it.
  assign o_busy = w_draining || (i_bubble_req && (i_bubble_len != '0) && !i_flush);

  // NOTE: all state below is written with non-blocking assignments so every
  // stage samples its predecessor's pre-edge value and the shift is a true
  // register chain rather than a fall-through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the pipeline is a handful of flops, not a RAM, so clearing it
      // asynchronously is cheap and gives downstream a defined zero vector.
      r_ctrl         <= '0;
      r_valid        <= '0;
      r_bubble_left  <= '0;
      r_bubble_total <= '0;
    end else if (!i_hold) begin
      // Older stages shift; the youngest FLUSH_DEPTH-1 stages above stage 0
      // are squashed on flush. Valid and vector move together, which keeps
      // every invalid stage at an all-zero vector.
      for (int i = 1; i < STAGES; i++) begin
        if (i_flush && (i < FLUSH_DEPTH)) begin
          r_ctrl[i]  <= '0;
          r_valid[i] <= 1'b0;
        end else begin
          r_ctrl[i]  <= r_ctrl[i-1];
          r_valid[i] <= r_valid[i-1];
        end
      end

      if (i_flush) begin
        r_ctrl[0]     <= '0;
        r_valid[0]    <= 1'b0;
        r_bubble_left <= '0;
      end else if (w_bubble) begin
        r_ctrl[0]     <= '0;
        r_valid[0]    <= 1'b0;
        r_bubble_left <= w_draining ? (r_bubble_left - BCNT_ONE)
                                    : (i_bubble_len - BCNT_ONE);
        if (r_bubble_total != TOTAL_MAX) begin
          r_bubble_total <= r_bubble_total + 16'd1;
        end
      end else if (i_ctrl_en && i_valid_in) begin
        r_ctrl[0]  <= i_ctrl_in;
        r_valid[0] <= 1'b1;
      end else begin
        r_ctrl[0]  <= '0;
        r_valid[0] <= 1'b0;
      end
    end
  end

  assign o_ctrl_stage   = r_ctrl;
  assign o_valid_stage  = r_valid;
  assign o_bubble_left  = r_bubble_left;
  assign o_bubble_total = r_bubble_total;

endmodule

// File: tb/tb_ctrl_pipe_bubble.sv
// Self-checking bench for ctrl_pipe_bubble: a behavioural model of the
// pipeline as a list of (valid, vector) slots is compared against the DUT on
// every falling edge, and directed scenarios pin the model with literals.
module tb_ctrl_pipe_bubble;

  localparam int CTRL_W      = 10;
  localparam int STAGES      = 3;
  localparam int FLUSH_DEPTH = 2;
  localparam int BCNT_W      = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     ctrl_en = 1'b0;
  logic [CTRL_W-1:0]        ctrl_in = '0;
  logic                     valid_in = 1'b0;
  logic                     hold = 1'b0;
  logic                     flush = 1'b0;
  logic                     bubble_req = 1'b0;
  logic [BCNT_W-1:0]        bubble_len = '0;
  logic [STAGES*CTRL_W-1:0] ctrl_stage;
  logic [STAGES-1:0]        valid_stage;
  logic                     busy;
  logic [BCNT_W-1:0]        bubble_left;
  logic [15:0]              bubble_total;

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_pipe_bubble #(
    .CTRL_W(CTRL_W), .STAGES(STAGES), .FLUSH_DEPTH(FLUSH_DEPTH), .BCNT_W(BCNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ctrl_en(ctrl_en), .i_ctrl_in(ctrl_in), .i_valid_in(valid_in),
    .i_hold(hold), .i_flush(flush),
    .i_bubble_req(bubble_req), .i_bubble_len(bubble_len),
    .o_ctrl_stage(ctrl_stage), .o_valid_stage(valid_stage), .o_busy(busy),
    .o_bubble_left(bubble_left), .o_bubble_total(bubble_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_vec [STAGES];   // slot 0 is the youngest instruction
  int m_val [STAGES];
  int m_left;           // bubbles still owed
  int m_total;          // bubbles inserted, clamped at 65535

  function automatic logic [STAGES*CTRL_W-1:0] m_ctrl_flat();
    logic [STAGES*CTRL_W-1:0] v = '0;
    for (int i = 0; i < STAGES; i++) v[i*CTRL_W +: CTRL_W] = CTRL_W'(m_vec[i]);
    return v;
  endfunction

  function automatic logic [STAGES-1:0] m_valid_flat();
    logic [STAGES-1:0] v = '0;
    for (int i = 0; i < STAGES; i++) v[i] = (m_val[i] != 0);
    return v;
  endfunction

  function automatic logic m_busy();
    return (m_left > 0) || (bubble_req && bubble_len != 0 && !flush);
  endfunction

  // Insert one slot at the young end; everything else ages by one.
  task automatic m_push(input int vec, input int val);
    for (int i = STAGES - 1; i > 0; i--) begin
      m_vec[i] = m_vec[i-1];
      m_val[i] = m_val[i-1];
    end
    m_vec[0] = vec;
    m_val[0] = val;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin m_vec[i] = 0; m_val[i] = 0; end
      m_left  = 0;
      m_total = 0;
    end else if (!hold) begin
      if (flush) begin
        m_push(0, 0);
        for (int i = 1; i < FLUSH_DEPTH; i++) begin m_vec[i] = 0; m_val[i] = 0; end
        m_left = 0;
      end else if (m_left > 0 || (bubble_req && bubble_len != 0)) begin
        m_push(0, 0);
        m_left  = (m_left > 0) ? m_left - 1 : int'(bubble_len) - 1;
        m_total = (m_total < 65535) ? m_total + 1 : 65535;
      end else if (ctrl_en && valid_in) begin
        m_push(int'(ctrl_in), 1);
      end else begin
        m_push(0, 0);
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cyc_ctrl",  64'(ctrl_stage),   64'(m_ctrl_flat()));
    check("cyc_valid", 64'(valid_stage),  64'(m_valid_flat()));
    check("cyc_busy",  64'(busy),         64'(m_busy()));
    check("cyc_left",  64'(bubble_left),  64'(m_left));
    check("cyc_total", 64'(bubble_total), 64'(m_total));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [STAGES*CTRL_W-1:0] pack3(input logic [9:0] s2, input logic [9:0] s1, input logic [9:0] s0);
    return {s2, s1, s0};
  endfunction

  task automatic feed(input logic [9:0] v);
    ctrl_in = v; tick();
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_ctrl",  64'(ctrl_stage), 0);
    check("rst_valid", 64'(valid_stage), 0);
    check("rst_total", 64'(bubble_total), 0);
    tick();
    rst = 1'b0;

    // Streaming: 2A1 walks through all three stages
    ctrl_en = 1'b1; valid_in = 1'b1;
    feed(10'h2A1);
    check("s1_st0",   64'(ctrl_stage[9:0]), 64'h2A1);
    check("s1_valid", 64'(valid_stage), 64'b001);
    feed(10'h155);
    check("s2_st1",   64'(ctrl_stage[19:10]), 64'h2A1);
    check("s2_valid", 64'(valid_stage), 64'b011);
    feed(10'h0F0);
    check("s3_all",   64'(ctrl_stage), 64'(pack3(10'h2A1, 10'h155, 10'h0F0)));
    check("s3_valid", 64'(valid_stage), 64'b111);

    // Two-bubble request with 3FF waiting in decode
    ctrl_in = 10'h3FF; bubble_req = 1'b1; bubble_len = 3'd2;
    #1;
    check("b_busy_pre", 64'(busy), 1);
    tick();
    bubble_req = 1'b0; bubble_len = '0;
    check("b1_ctrl", 64'(ctrl_stage), 64'(pack3(10'h155, 10'h0F0, 10'h000)));
    check("b1_left", 64'(bubble_left), 1);
    check("b1_busy", 64'(busy), 1);
    tick();
    check("b2_left",  64'(bubble_left), 0);
    check("b2_total", 64'(bubble_total), 2);
    check("b2_busy",  64'(busy), 0);
    tick();
    check("b3_ctrl",  64'(ctrl_stage), 64'(pack3(10'h000, 10'h000, 10'h3FF)));
    check("b3_valid", 64'(valid_stage), 64'b001);

    // Flush with stages A, B, C (stage 0 = A)
    feed(10'h0C3); feed(10'h0B2); feed(10'h0A1);
    ctrl_in = 10'h111; flush = 1'b1; bubble_req = 1'b1; bubble_len = 3'd4;
    #1;
    check("f_busy_pre", 64'(busy), 0);
    tick();
    flush = 1'b0; bubble_req = 1'b0; bubble_len = '0;
    check("f_ctrl",  64'(ctrl_stage), 64'(pack3(10'h0B2, 10'h000, 10'h000)));
    check("f_valid", 64'(valid_stage), 64'b100);
    check("f_total", 64'(bubble_total), 2);
    check("f_left",  64'(bubble_left), 0);

    // Hold and flush together during a 3-bubble drain
    feed(10'h101); feed(10'h102);
    ctrl_in = 10'h103; bubble_req = 1'b1; bubble_len = 3'd3;
    tick();
    bubble_req = 1'b0; bubble_len = '0;
    check("h0_left", 64'(bubble_left), 2);
    hold = 1'b1; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("h_ctrl",  64'(ctrl_stage), 64'(pack3(10'h101, 10'h102, 10'h000)));
      check("h_left",  64'(bubble_left), 2);
      check("h_total", 64'(bubble_total), 3);
      check("h_busy",  64'(busy), 1);
    end
    hold = 1'b0;
    tick();
    flush = 1'b0;
    check("hf_left", 64'(bubble_left), 0);
    check("hf_ctrl", 64'(ctrl_stage), 64'(pack3(10'h102, 10'h000, 10'h000)));
    check("hf_total", 64'(bubble_total), 3);

    // Enable gating
    ctrl_en = 1'b0; valid_in = 1'b1; ctrl_in = 10'h3FF;
    tick();
    check("en_st0",   64'(ctrl_stage[9:0]), 0);
    check("en_valid", 64'(valid_stage[0]), 0);
    ctrl_en = 1'b1;

    // Async reset mid-bubble, between clock edges
    feed(10'h2AA);
    bubble_req = 1'b1; bubble_len = 3'd5;
    tick();
    bubble_req = 1'b0; bubble_len = '0;
    tick();
    check("ar_left_pre", 64'(bubble_left), 3);
    #2 rst = 1'b1;
    #1;
    check("ar_ctrl",  64'(ctrl_stage), 0);
    check("ar_valid", 64'(valid_stage), 0);
    check("ar_left",  64'(bubble_left), 0);
    check("ar_total", 64'(bubble_total), 0);
    check("ar_busy",  64'(busy), 0);
    tick();
    rst = 1'b0;
    feed(10'h155);
    check("ar_after", 64'(ctrl_stage), 64'(pack3(10'h000, 10'h000, 10'h155)));

    // Saturation: request held high, so every cycle inserts a bubble
    bubble_req = 1'b1; bubble_len = 3'd7;
    for (int k = 0; k < 65540; k++) tick();
    check("sat_total", 64'(bubble_total), 64'hFFFF);
    tick();
    check("sat_hold", 64'(bubble_total), 64'hFFFF);
    bubble_req = 1'b0; bubble_len = '0;
    for (int k = 0; k < 8; k++) tick();
    check("sat_idle", 64'(busy), 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
